// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg: shared FSM state type and sizing helpers for the truth-table checker
package truth_table_checker_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int N_IN_DEF = 4;
  localparam int NVEC = 1 << N_IN_DEF;
  localparam int CNT_W = N_IN_DEF + 1;
  function automatic int nvec_f(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// settle_timer: 4-bit loadable down-counter that stops at zero
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0 ? cnt - 4'd1 : cnt);
  assign zero = (cnt == '0);
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all input vectors, compares f_a against f_b, records mismatches and the on-set of f_a
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [N_IN-1:0]           stim,
  input  logic                      f_a,
  input  logic                      f_b,
  output logic                      busy,
  output logic                      done,
  output logic                      equal,
  output logic [N_IN:0]             mismatch_count,
  output logic [N_IN-1:0]           first_mismatch,
  output logic [nvec_f(N_IN)-1:0]   onset_a
);
  state_t state, state_nx;
  logic   zero, sample, last, accept, load;
  assign accept = (state == IDLE) && start;
  assign sample = (state == RUN) && zero;
  assign last   = &stim;
  assign load   = accept || (sample && !last);
  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (4'(SETTLE)),
    .zero     (zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = (sample && last) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stim           <= '0;
      equal          <= 1'b0;
      mismatch_count <= '0;
      first_mismatch <= '0;
      onset_a        <= '0;
    end else if (accept) begin
      stim           <= '0;
      equal          <= 1'b0;
      mismatch_count <= '0;
      first_mismatch <= '0;
      onset_a        <= '0;
    end else if (sample) begin
      onset_a[stim] <= f_a;
      if (f_a != f_b) begin
        mismatch_count <= mismatch_count + 1'b1;
        if (mismatch_count == '0) first_mismatch <= stim;
      end
      if (!last) stim <= stim + 1'b1;
    end else if (state == DONE) begin
      equal <= (mismatch_count == '0);
      stim  <= '0;
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: three checker configurations driven by table-defined and pipelined functions, checked against a sweep model
module tb_truth_table_checker;
  import truth_table_checker_pkg::*;
  localparam int NI [3] = '{3, 4, 4};
  localparam int ST [3] = '{0, 0, 2};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0]  start = '0;
  logic [2:0]  fa, fb, p1, p2;
  logic        mode = 1'b0;
  logic [15:0] ta = '0, tbt = '0;
  logic [2:0] s3, fm3;
  logic [3:0] mc3;
  logic [7:0] on3;
  logic       b3, d3, e3;
  logic [N_IN_DEF-1:0] s4, fm4, s4s, fm4s;
  logic [CNT_W-1:0]    mc4, mc4s;
  logic [NVEC-1:0]     on4, on4s;
  logic                b4, d4, e4, b4s, d4s, e4s;
  logic [3:0]  sv [3];
  logic [4:0]  mcv [3];
  logic [3:0]  fmv [3];
  logic [15:0] onv [3];
  logic        bv [3], dv [3], ev [3];
  truth_table_checker #(.N_IN(3), .SETTLE(0)) u3 (
    .clk(clk), .rst(rst), .start(start[0]), .stim(s3), .f_a(fa[0]), .f_b(fb[0]),
    .busy(b3), .done(d3), .equal(e3), .mismatch_count(mc3), .first_mismatch(fm3), .onset_a(on3));
  truth_table_checker #(.N_IN(4), .SETTLE(0)) u4 (
    .clk(clk), .rst(rst), .start(start[1]), .stim(s4), .f_a(fa[1]), .f_b(fb[1]),
    .busy(b4), .done(d4), .equal(e4), .mismatch_count(mc4), .first_mismatch(fm4), .onset_a(on4));
  truth_table_checker #(.N_IN(4), .SETTLE(2)) u4s (
    .clk(clk), .rst(rst), .start(start[2]), .stim(s4s), .f_a(fa[2]), .f_b(fb[2]),
    .busy(b4s), .done(d4s), .equal(e4s), .mismatch_count(mc4s), .first_mismatch(fm4s), .onset_a(on4s));
  always_comb begin
    sv[0] = {1'b0, s3}; mcv[0] = {1'b0, mc3}; fmv[0] = {1'b0, fm3}; onv[0] = {8'h00, on3};
    bv[0] = b3; dv[0] = d3; ev[0] = e3;
    sv[1] = s4; mcv[1] = mc4; fmv[1] = fm4; onv[1] = on4; bv[1] = b4; dv[1] = d4; ev[1] = e4;
    sv[2] = s4s; mcv[2] = mc4s; fmv[2] = fm4s; onv[2] = on4s; bv[2] = b4s; dv[2] = d4s; ev[2] = e4s;
    for (int i = 0; i < 3; i++) begin
      fa[i] = mode ? ^sv[i] : ta[sv[i]];
      fb[i] = mode ? p2[i] : tbt[sv[i]];
    end
  end
  // f_b in pipeline mode is parity delayed through two registers
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      p1[i] <= ^sv[i];
      p2[i] <= p1[i];
    end
  int n_tests = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input int n, input logic [15:0] a, input logic [15:0] b,
                                output int cnt, output int first, output logic [15:0] on);
    cnt = 0; first = 0; on = '0;
    for (int i = 0; i < (1 << n); i++) begin
      on[i] = a[i];
      if (a[i] != b[i]) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endfunction
  task automatic check_zero(input int k, input string tag);
    check({tag, "_busy"}, 32'(bv[k]), 0);
    check({tag, "_done"}, 32'(dv[k]), 0);
    check({tag, "_equal"}, 32'(ev[k]), 0);
    check({tag, "_stim"}, 32'(sv[k]), 0);
    check({tag, "_count"}, 32'(mcv[k]), 0);
    check({tag, "_first"}, 32'(fmv[k]), 0);
    check({tag, "_onset"}, 32'(onv[k]), 0);
  endtask
  task automatic run(input int k, input bit pipe, input int rst_at, input int start_at);
    int cyc, dcyc, cnt, first, len, bad;
    logic [15:0] on;
    len = (1 << NI[k]) * (ST[k] + 1);
    mode = pipe;
    if (pipe) begin
      for (int i = 0; i < 16; i++) ta[i] = ^(4'(i));
      tbt = ta;
    end
    model(NI[k], ta, tbt, cnt, first, on);
    @(negedge clk);
    start[k] = 1'b1;
    cyc = 0;
    dcyc = -1;
    while (cyc < len + 20) begin
      @(negedge clk);
      cyc++;
      if (dv[k]) begin
        dcyc = cyc;
        break;
      end
      if (cyc <= len) begin
        check("busy_run", 32'(bv[k]), 1);
        check("stim_run", 32'(sv[k]), 32'((cyc - 1) / (ST[k] + 1)));
      end
      start[k] = (cyc == start_at);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check_zero(k, "mid_rst");
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (len + 5) begin
          @(negedge clk);
          if (dv[k] || bv[k]) bad++;
        end
        check("no_done_after_rst", 32'(bad), 0);
        return;
      end
    end
    start[k] = 1'b0;
    check("done_cycle", 32'(dcyc), 32'(len + 1));
    @(negedge clk);
    check("busy_after", 32'(bv[k]), 0);
    check("done_pulse", 32'(dv[k]), 0);
    check("stim_after", 32'(sv[k]), 0);
    check("onset", 32'(onv[k]), 32'(on));
    if (pipe && ST[k] == 0) begin
      check("count_nonzero", 32'(mcv[k] != 0), 1);
      check("equal", 32'(ev[k]), 0);
    end else begin
      check("count", 32'(mcv[k]), 32'(cnt));
      check("first", 32'(fmv[k]), 32'(first));
      check("equal", 32'(ev[k]), 32'(cnt == 0));
    end
    mode = 1'b0;
  endtask
  initial begin
    int k, c, dc;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    rst = 1'b0;
    ta = 16'h0055; tbt = 16'h0055;
    run(0, 0, 0, 0);
    ta = 16'h00AA; tbt = 16'h0055;
    run(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) tbt[i] = ~^(4'(i));
    ta = tbt ^ 16'h0400;
    run(1, 0, 0, 0);
    run(1, 1, 0, 0);
    run(2, 1, 0, 0);
    ta = 16'($urandom); tbt = 16'($urandom);
    run(1, 0, 0, 5);
    run(2, 0, 0, 7);
    run(2, 0, 5, 0);
    ta = 16'($urandom); tbt = ta ^ 16'h8001;
    run(2, 0, 0, 0);
    // start held high across a full sweep re-arms on the first IDLE cycle
    ta = 16'h00F0; tbt = 16'h00F0;
    @(negedge clk);
    start[0] = 1'b1;
    c = 0; dc = -1;
    while (c < 40 && dc < 0) begin
      @(negedge clk);
      c++;
      if (d3) dc = c;
    end
    check("held_done_cycle", 32'(dc), 9);
    @(negedge clk);
    check("held_idle", 32'(b3), 0);
    @(negedge clk);
    check("held_restart", 32'(b3), 1);
    start[0] = 1'b0;
    c = 0;
    while (c < 40 && !d3) begin
      @(negedge clk);
      c++;
    end
    check("held_second_done", 32'(d3), 1);
    @(negedge clk);
    check("held_equal", 32'(e3), 1);
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(0, 2);
      ta = 16'($urandom);
      c = $urandom_range(0, 2);
      tbt = (c == 0) ? ta : (c == 1) ? ta ^ (16'h1 << $urandom_range(0, (1 << NI[k]) - 1)) : 16'($urandom);
      run(k, 0, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Sequential, parametrised exhaustive equivalence checker for N-input Boolean functions. On `start` it sweeps every input vector 0..2^N−1 on `stim`. It samples two externally wired implementations of the same function, for example a product-of-sums form and its simplified form, and reports the following:
- a mismatch count;
- the first mismatching vector;
- the minterm on-set of implementation A.

It is the lab-bench harness for all combinational exercise blocks, replacing manual truth-table comparison.

## Interface
- `N_IN`, default 4: number of function inputs; legal range 2..6.
- `SETTLE`, default 0: extra wait cycles after driving a vector before sampling; legal range 0..15.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin sweep; accepted only in IDLE.
- `stim`  out  N_IN  input vector driven to both implementations; `stim[0]` is the least significant variable.
- `f_a`  in  1  output of implementation A.
- `f_b`  in  1  output of implementation B.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse when results are final.
- `equal`  out  1  1 when the last sweep found zero mismatches.
- `mismatch_count`  out  N_IN+1  number of vectors where `f_a != f_b`.
- `first_mismatch`  out  N_IN  lowest vector with a mismatch; valid only if `mismatch_count != 0`.
- `onset_a`  out  2^N_IN  bit i = `f_a` sampled at `stim == i`.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE → RUN** on `start`. At that edge:
  - `stim` ← 0, settle counter ← SETTLE;
  - `mismatch_count`, `first_mismatch`, `onset_a` cleared;
  - `equal` ← 0.
- **RUN, settle counter ≠ 0:** decrement the counter and hold `stim`.
- **RUN, settle counter = 0 (sample edge):**
  - `onset_a[stim]` ← `f_a`;
  - if `f_a != f_b`: increment `mismatch_count`; if the count was 0, `first_mismatch` ← `stim`;
  - if `stim == 2^N_IN−1`, go to DONE; otherwise `stim` ← `stim`+1 and the counter reloads SETTLE.
- **DONE → IDLE** unconditionally after one cycle. On the DONE→IDLE edge:
  - `equal` ← (`mismatch_count == 0`);
  - `stim` ← 0.
- Outputs:
  - `busy` = (state == RUN);
  - `done` = (state == DONE);
  - `equal` is registered and holds until the next accepted `start`.
- Results hold in IDLE until the next accepted `start`.
- Boundary conditions:
  - `start` during RUN or DONE is ignored; there is no queued restart.
  - `start` held high continuously restarts on every IDLE cycle.
  - `mismatch_count` reaches at most 2^N_IN and never wraps; the width N_IN+1 guarantees this.
  - `onset_a` bit index equals `stim` value; there is no reordering.
- `f_a` and `f_b` are sampled with no internal synchroniser. The implementations must settle within SETTLE+1 cycles of `stim` changing.

## Timing
- Reset values:
  - state IDLE;
  - `stim` 0, `busy` 0, `done` 0, `equal` 0;
  - `mismatch_count` 0, `first_mismatch` 0, `onset_a` 0.
- Asserting `rst` mid-sweep aborts immediately to reset values, with no `done` pulse.
- With `start` accepted at edge 0:
  - RUN occupies cycles 1 .. 2^N_IN·(SETTLE+1);
  - `done` is high in cycle 2^N_IN·(SETTLE+1)+1;
  - `equal` is valid from the following cycle.
- Each vector is held for exactly SETTLE+1 cycles. Sampling happens at the last edge of that hold.

## Structure
- Shared package holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparams `NVEC = 1 << N_IN` and `CNT_W = N_IN+1`.
- One sub-module, `settle_timer`:
  - 4-bit loadable down-counter;
  - inputs `load`, `load_val`;
  - output `zero`.
- The FSM, vector counter and result registers stay in the top module.

## Test plan
- **N_IN=3, SETTLE=0, `f_a = f_b = ~stim[0]`:** `done` in cycle 9, `equal`=1, `mismatch_count`=0, `onset_a`=8'b01010101.
- **N_IN=3, `f_a = stim[0]`, `f_b = ~stim[0]`:** `mismatch_count`=8, `first_mismatch`=0, `equal`=0, `onset_a`=8'b10101010.
- **N_IN=4, `f_b` = 4-input XNOR, `f_a` = XNOR XOR (`stim == 10`):** `mismatch_count`=1, `first_mismatch`=10.
- **SETTLE sweep, `f_b` = `f_a` delayed by a 2-stage register pipeline, `f_a` = parity:**
  - SETTLE=0 gives `mismatch_count` > 0;
  - SETTLE=2 gives `equal`=1, with `done` in cycle 16·3+1 = 49 for N_IN=4.
- **Reset and start handling:**
  - `rst` pulsed at cycle 5 of a run: all outputs return to 0 and no `done` appears;
  - a new `start` afterwards completes normally;
  - `start` pulsed during RUN does not alter `stim` progression or the `done` timing.
